// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - register-programmable GPIO bank with synchronised inputs and edge interrupts
// Per-bit output/enable registers, input synchroniser, edge-detect status with W1C and a post-reset arm window.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [ARM_W-1:0] arm_q, arm_d;

    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] rise_hit;
    logic [WIDTH-1:0] fall_hit;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] rd_val;

    assign in_val   = sync_q[SYNC_STAGES-1];
    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;
    assign rdata    = rdata_q;
    assign irq      = |status_q;

    always_comb begin
        rise_hit = in_val & ~prev_q;
        fall_hit = ~in_val & prev_q;
        // Edges are discarded until the synchroniser and prev have refilled after reset.
        if (arm_q == '0) begin
            edge_hit = (rise_hit & rise_en_q) | (fall_hit & fall_en_q);
        end else begin
            edge_hit = '0;
        end

        case (addr)
            3'd0:    rd_val = out_q;
            3'd1:    rd_val = oe_q;
            3'd2:    rd_val = in_val;
            3'd3:    rd_val = rise_en_q;
            3'd4:    rd_val = fall_en_q;
            3'd5:    rd_val = status_q;
            default: rd_val = '0;
        endcase

        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        status_d  = status_q;
        if (we) begin
            case (addr)
                3'd0:    out_d     = wdata;
                3'd1:    oe_d      = wdata;
                3'd3:    rise_en_d = wdata;
                3'd4:    fall_en_d = wdata;
                3'd5:    status_d  = status_q & ~wdata;
                3'd6:    out_d     = out_q | wdata;
                3'd7:    out_d     = out_q & ~wdata;
                default: ;
            endcase
        end
        // A newly detected edge wins over a simultaneous W1C.
        status_d = status_d | edge_hit;

        rdata_d = re ? rd_val : rdata_q;

        if (arm_q != '0) begin
            arm_d = arm_q - ARM_W'(1);
        end else begin
            arm_d = arm_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q    <= '0;
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
            arm_q     <= ARM_LOAD;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q    <= in_val;
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            arm_q     <= arm_d;
        end
    end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised general-purpose I/O bank for the rv32e minimal MCU. It generalises the fixed pin mapping in the top-level wrapper into a register-programmable port. Each bit has its own output value, output enable, synchronised input and edge-triggered interrupt. It sits between the CPU's peripheral register bus and the TinyTapeout `uio_*` / `uo_out` / `ui_in` pins, and drives one interrupt line to the core.

## Interface
Parameters:
- `WIDTH`, default 8: number of GPIO bits, legal range 1..32.
- `SYNC_STAGES`, default 2: input synchroniser depth, must be 2 or more.

Ports:
- `clk`  in  1: the single clock; every flop is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `addr`  in  3: register select.
- `wdata`  in  WIDTH: write data.
- `we`  in  1: write strobe, one write per cycle.
- `re`  in  1: read strobe.
- `rdata`  out  WIDTH: registered read data.
- `gpio_in`  in  WIDTH: asynchronous pin inputs.
- `gpio_out`  out  WIDTH: pin output values.
- `gpio_oe`  out  WIDTH: pin output enables, 1 = drive.
- `irq`  out  1: level interrupt, equal to the OR of all STATUS bits.

## Operation
Register map by `addr`:
- 0 OUT (R/W).
- 1 OE (R/W).
- 2 IN (RO, synchronised pin value).
- 3 RISE_EN (R/W).
- 4 FALL_EN (R/W).
- 5 STATUS (R/W1C).
- 6 OUT_SET (WO, write-1-to-set OUT bits).
- 7 OUT_CLR (WO, write-1-to-clear OUT bits).

Register behaviour:
- Writes to IN are ignored.
- Reads of addresses 6 and 7 return 0.
- `gpio_out` = OUT and `gpio_oe` = OE, driven directly from flops with no combinational path from the bus.

Input path and edge detection:
- `gpio_in` passes through a SYNC_STAGES-deep flop chain; the last stage is IN.
- A `prev` register holds IN delayed by one cycle.
- Rising edge on bit i: IN[i] & ~prev[i]. Falling edge: ~IN[i] & prev[i].
- STATUS[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- STATUS bits stay set until software clears them with W1C.
- Edge detection is masked while a post-reset arm counter runs, for SYNC_STAGES+1 cycles after `rst` deasserts. This prevents spurious edges while the pipeline fills.

Read port:
- When `re` is high, `rdata` captures the addressed register on the next clock edge.
- When `re` is low, `rdata` holds its last value.
- If `we` and `re` are both high for the same address, `rdata` returns the pre-write value.

Reset:
- OUT, OE, RISE_EN, FALL_EN, STATUS, the synchroniser chain, `prev` and `rdata` all go to 0.
- Therefore `gpio_out`=0, `gpio_oe`=0 and `irq`=0 at reset.
- The arm counter reloads, so edge detection is masked again.
- Asserting `rst` mid-operation has the same effect, including dropping a pending `irq` in the cycle after `rst` is sampled.

Simultaneous events:
- A W1C of STATUS[i] in the same cycle a new qualifying edge on bit i is detected: set wins, and STATUS[i] stays 1.
- OUT_SET / OUT_CLR cannot collide, because only one write happens per cycle.
- Changing RISE_EN or FALL_EN does not retroactively set or clear STATUS.

## Timing
- Register write: takes effect at the clock edge where `we` is sampled. `gpio_out` / `gpio_oe` change on that edge.
- Read latency: 1 cycle. `rdata` is valid after the edge that samples `re`.
- Pin input latency: a change on `gpio_in` that is stable before edge k appears in IN after edge k+SYNC_STAGES-1.
  - This is 2 edges with the default parameters: edges k and k+1.
- Interrupt latency: the same change sets STATUS, and raises `irq`, one edge after it appears in IN.
  - `irq` is combinational from STATUS flops only.
- Pulse width: a pin pulse shorter than one clock period may be missed; there is no pulse-capture guarantee.
- Arm window: edges reaching IN during the first SYNC_STAGES+1 cycles after reset release are discarded.

## Test plan
1. Reset check (WIDTH=8): assert `rst` 2 cycles, then read all 8 addresses -> every read returns 0x00, `gpio_out`=0x00, `gpio_oe`=0x00, `irq`=0.
2. Output set/clear: write OUT=0xA5, then OUT_SET=0x0A, then OUT_CLR=0x81 -> `gpio_out` is 0xA5, then 0xAF, then 0x2E, each on the write edge. Reading OUT returns 0x2E; reading address 6 returns 0x00.
3. Input sync latency: after the arm window, drive `gpio_in` 0x00 -> 0x3C just before edge k -> IN reads 0x00 when sampled at edge k, 0x3C when sampled at edge k+2. STATUS stays 0 while RISE_EN=0.
4. Edge interrupts: set RISE_EN=0x01 and FALL_EN=0x80. Toggle bit 0 high and bit 7 high->low -> STATUS=0x81 and `irq`=1 exactly 3 edges after the pin change. Write STATUS=0x01 -> STATUS=0x80 and `irq` stays 1. Write STATUS=0x80 -> `irq`=0.
5. Clear/set collision: with RISE_EN=0x04, time a W1C of 0x04 into the cycle in which a bit-2 rising edge is detected -> STATUS[2] stays 1.
6. Reset mid-operation: with STATUS=0xFF, OE=0xFF, and `gpio_in`=0xFF held high, pulse `rst` for 1 cycle. Expected:
   - `irq`=0 and `gpio_oe`=0x00 the cycle after.
   - No STATUS bit sets during the arm window.
   - IN reads 0xFF afterward.
